// File: rtl/voter_ballot.sv
// voter_ballot: sequential ballot collector for a four-member voting panel.
// It opens a session on START and accepts one vote per member. It closes when
// all four members have cast. It then holds the ballot vector, the yes tally
// and the verdict stable for the downstream combinational voter.
// Optional feature: define VOTER_TIMEOUT_EN to build the session window timer.
// With the timer, a session also closes after WINDOW cycles even if some members
// have not voted. Without it, WINDOW is ignored and a session waits for all votes.
module voter_ballot #(
  parameter int WINDOW = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] VOTE_VLD,
  input  logic [3:0] VOTE_VAL,
  output logic [3:0] I,
  output logic [3:0] CAST,
  output logic [2:0] YES_CNT,
  output logic [1:0] VERDICT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OPEN  = 2'b01,
    ST_CLOSE = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  // A window outside 1..255 cannot be loaded into the 8-bit timer.
  if ((WINDOW < 32'sd1) || (WINDOW > 32'sd255)) begin : g_window_range
    $error("voter_ballot: WINDOW must be in the range 1..255");
  end

  // Number of set bits in a 4-bit vote vector (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Verdict encoding: pass on 3+ yes; tie needs exactly 2 yes with all four cast.
  function automatic logic [1:0] verdict_of(input logic [2:0] yes, input logic [3:0] cast);
    if (yes >= 3'd3) begin
      verdict_of = 2'b01;
    end else if ((yes == 3'd2) && (cast == 4'b1111)) begin
      verdict_of = 2'b10;
    end else begin
      verdict_of = 2'b00;
    end
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] i_r;
  logic [3:0] i_next_s;
  logic [3:0] cast_r;
  logic [3:0] cast_next_s;
  logic [2:0] yes_cnt_r;
  logic [2:0] yes_next_s;
  logic [1:0] verdict_r;
  logic [1:0] verdict_next_s;
  logic       busy_r;
  logic       busy_next_s;
  logic       done_r;
  logic       done_next_s;
  logic [3:0] accept_s;
  logic       expire_s;

`ifdef VOTER_TIMEOUT_EN
  localparam logic [7:0] WINDOW_LOAD = 8'(WINDOW - 32'sd1);

  logic       open_entry_s;
  logic [7:0] timer_r;
  logic [7:0] timer_next_s;

  // A session is opened exactly when START lands in IDLE or HOLD.
  assign open_entry_s = START & ((state_r == ST_IDLE) | (state_r == ST_HOLD));
  // Timer reads 0 during the WINDOW-th OPEN cycle, which is the last one.
  assign expire_s = (timer_r == 8'd0);

  // Window timer: load on session open, count down while OPEN.
  always_comb begin
    timer_next_s = timer_r;
    if (open_entry_s) begin
      timer_next_s = WINDOW_LOAD;
    end else if ((state_r == ST_OPEN) && (timer_r != 8'd0)) begin
      timer_next_s = timer_r - 8'd1;
    end else begin
      timer_next_s = timer_r;
    end
  end

  // Window timer register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_r <= 8'd0;
    end else begin
      timer_r <= timer_next_s;
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and next-output logic for the session FSM.
  always_comb begin
    state_next_s   = state_r;
    i_next_s       = i_r;
    cast_next_s    = cast_r;
    yes_next_s     = yes_cnt_r;
    verdict_next_s = verdict_r;
    accept_s       = 4'b0000;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (START) begin
          state_next_s   = ST_OPEN;
          i_next_s       = 4'b0000;
          cast_next_s    = 4'b0000;
          yes_next_s     = 3'd0;
          verdict_next_s = 2'b00;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_OPEN: begin
        // Only first votes are accepted; a member's bit of I is still 0 until
        // that member is accepted, so OR-ing in the new yes bits is exact.
        accept_s    = VOTE_VLD & ~cast_r;
        cast_next_s = cast_r | accept_s;
        i_next_s    = i_r | (accept_s & VOTE_VAL);
        yes_next_s  = yes_cnt_r + popcount4(accept_s & VOTE_VAL);
        if ((cast_next_s == 4'b1111) || expire_s) begin
          state_next_s = ST_CLOSE;
        end else begin
          state_next_s = ST_OPEN;
        end
      end
      ST_CLOSE: begin
        verdict_next_s = verdict_of(yes_cnt_r, cast_r);
        state_next_s   = ST_HOLD;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    busy_next_s = (state_next_s == ST_OPEN) || (state_next_s == ST_CLOSE);
    done_next_s = (state_r == ST_CLOSE);
  end

  // State and output registers; reset aborts any session without a DONE pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      i_r       <= 4'b0000;
      cast_r    <= 4'b0000;
      yes_cnt_r <= 3'd0;
      verdict_r <= 2'b00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      i_r       <= i_next_s;
      cast_r    <= cast_next_s;
      yes_cnt_r <= yes_next_s;
      verdict_r <= verdict_next_s;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
    end
  end

  assign I       = i_r;
  assign CAST    = cast_r;
  assign YES_CNT = yes_cnt_r;
  assign VERDICT = verdict_r;
  assign BUSY    = busy_r;
  assign DONE    = done_r;

endmodule

// File: tb/tb_voter_ballot.sv
// Self-checking bench for voter_ballot. Each finished ballot is predicted and
// queued when its closing stimulus is driven; a negedge monitor pops and
// compares it when DONE pulses. Scenario tasks also check cycle-level behaviour.
`timescale 1ns/1ps
module tb_voter_ballot;

  typedef struct packed {
    logic [3:0] i;
    logic [3:0] cast;
    logic [2:0] yes;
    logic [1:0] verdict;
  } result_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vote_vld;
  logic [3:0] vote_val;
  logic [3:0] i_o;
  logic [3:0] cast_o;
  logic [2:0] yes_o;
  logic [1:0] verdict_o;
  logic       busy_o;
  logic       done_o;

  result_t     exp_q[$];
  result_t     mon_exp;
  logic [14:0] exp_v;
  int          checks = 0;
  int          errors = 0;

  voter_ballot #(.WINDOW(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .VOTE_VLD(vote_vld), .VOTE_VAL(vote_val),
    .I(i_o), .CAST(cast_o), .YES_CNT(yes_o), .VERDICT(verdict_o),
    .BUSY(busy_o), .DONE(done_o)
  );

  always #5 clk = ~clk;

  // Observed vector layout: {BUSY, DONE, I, CAST, YES_CNT, VERDICT}
  function automatic logic [14:0] snap();
    return {busy_o, done_o, i_o, cast_o, yes_o, verdict_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every DONE pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got DONE=1 with result %b, expected no pending result",
                 {i_o, cast_o, yes_o, verdict_o});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({i_o, cast_o, yes_o, verdict_o} !== mon_exp) begin
          errors++;
          $display("FAIL sb_result: got I/CAST/YES/VERDICT %b, expected %b",
                   {i_o, cast_o, yes_o, verdict_o}, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vote_vld = 4'b0000; vote_val = 4'b0000;
    repeat (2) tick();
    exp_v = 15'b0;
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL reset_values: got %b expected %b", snap(), exp_v); end
    rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    vote_vld = 4'b0011; vote_val = 4'b0001; tick(); vote_vld = 4'b0000;
    exp_v = {1'b1, 1'b0, 4'b0001, 4'b0011, 3'd1, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL pre_abort: got %b expected %b", snap(), exp_v); end
    #2 rst = 1'b1;
    #1;
    exp_v = 15'b0;
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL async_abort: got %b expected %b", snap(), exp_v); end
    tick();
    rst = 1'b0;
    vote_vld = 4'b1111; vote_val = 4'b1111; tick(); vote_vld = 4'b0000;
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL idle_ignores_votes: got %b expected %b", snap(), exp_v); end
    repeat (2) tick();
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL no_done_after_abort: got %b expected %b", snap(), exp_v); end
  endtask

  task automatic test_block_vote(input logic [3:0] pattern);
    int         pc;
    logic [1:0] vd;
    pc = 0;
    for (int k = 0; k < 4; k++) pc += int'(pattern[k]);
    vd = (pc >= 3) ? 2'b01 : ((pc == 2) ? 2'b10 : 2'b00);
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL block_open_%b: got %b expected %b", pattern, snap(), exp_v); end
    vote_vld = 4'b1111; vote_val = pattern;
    exp_q.push_back('{pattern, 4'b1111, 3'(pc), vd});
    tick(); vote_vld = 4'b0000; vote_val = 4'b0000;
    exp_v = {1'b1, 1'b0, pattern, 4'b1111, 3'(pc), 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL block_close_%b: got %b expected %b", pattern, snap(), exp_v); end
    tick();
    exp_v = {1'b0, 1'b1, pattern, 4'b1111, 3'(pc), vd};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL block_hold_%b: got %b expected %b", pattern, snap(), exp_v); end
    tick();
    exp_v = {1'b0, 1'b0, pattern, 4'b1111, 3'(pc), vd};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL block_held_%b: got %b expected %b", pattern, snap(), exp_v); end
  endtask

  task automatic test_serial();
    start = 1'b1; tick(); start = 1'b0;
    vote_vld = 4'b0001; vote_val = 4'b0001; tick();
    vote_vld = 4'b0001; vote_val = 4'b0000; tick();
    exp_v = {1'b1, 1'b0, 4'b0001, 4'b0001, 3'd1, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL serial_repeat_ignored: got %b expected %b", snap(), exp_v); end
    vote_vld = 4'b0010; vote_val = 4'b0000; tick();
    vote_vld = 4'b0100; vote_val = 4'b0100; tick();
    exp_v = {1'b1, 1'b0, 4'b0101, 4'b0111, 3'd2, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL serial_partial: got %b expected %b", snap(), exp_v); end
    vote_vld = 4'b1000; vote_val = 4'b0000;
    exp_q.push_back('{4'b0101, 4'b1111, 3'd2, 2'b10});
    tick(); vote_vld = 4'b0000;
    tick();
    exp_v = {1'b0, 1'b1, 4'b0101, 4'b1111, 3'd2, 2'b10};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL serial_tie: got %b expected %b", snap(), exp_v); end
  endtask

  task automatic test_ignore();
    start = 1'b1; tick(); start = 1'b0;
    vote_vld = 4'b0001; vote_val = 4'b0001; tick(); vote_vld = 4'b0000;
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {1'b1, 1'b0, 4'b0001, 4'b0001, 3'd1, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL start_in_open: got %b expected %b", snap(), exp_v); end
    vote_vld = 4'b1110; vote_val = 4'b0110;
    exp_q.push_back('{4'b0111, 4'b1111, 3'd3, 2'b01});
    tick(); vote_vld = 4'b0000;
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {1'b0, 1'b1, 4'b0111, 4'b1111, 3'd3, 2'b01};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL start_in_close: got %b expected %b", snap(), exp_v); end
    vote_vld = 4'b1111; vote_val = 4'b0000; tick(); vote_vld = 4'b0000;
    exp_v = {1'b0, 1'b0, 4'b0111, 4'b1111, 3'd3, 2'b01};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL hold_ignores_votes: got %b expected %b", snap(), exp_v); end
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL hold_reopen: got %b expected %b", snap(), exp_v); end
    vote_vld = 4'b1111; vote_val = 4'b0000;
    exp_q.push_back('{4'b0000, 4'b1111, 3'd0, 2'b00});
    tick(); vote_vld = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; tick(); start = 1'b0;
    vote_vld = 4'b1111; vote_val = 4'b1100;
    exp_q.push_back('{4'b1100, 4'b1111, 3'd2, 2'b10});
    tick(); vote_vld = 4'b0000;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL start_on_done: got %b expected %b", snap(), exp_v); end
    vote_vld = 4'b1111; vote_val = 4'b1111;
    exp_q.push_back('{4'b1111, 4'b1111, 3'd4, 2'b01});
    tick(); vote_vld = 4'b0000;
    tick();
    exp_v = {1'b0, 1'b1, 4'b1111, 4'b1111, 3'd4, 2'b01};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL b2b_second_result: got %b expected %b", snap(), exp_v); end
  endtask

`ifdef VOTER_TIMEOUT_EN
  task automatic test_timeout();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    exp_v = {1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL timeout_last_open: got %b expected %b", snap(), exp_v); end
    vote_vld = 4'b0100; vote_val = 4'b0100;
    exp_q.push_back('{4'b0100, 4'b0100, 3'd1, 2'b00});
    tick(); vote_vld = 4'b0000;
    exp_v = {1'b1, 1'b0, 4'b0100, 4'b0100, 3'd1, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL timeout_close: got %b expected %b", snap(), exp_v); end
    tick();
    exp_v = {1'b0, 1'b1, 4'b0100, 4'b0100, 3'd1, 2'b00};
    checks++;
    if (snap() !== exp_v) begin errors++; $display("FAIL timeout_hold: got %b expected %b", snap(), exp_v); end
  endtask
`endif

  initial begin
    test_reset();
    test_block_vote(4'b1011);
    test_serial();
    test_ignore();
    test_back_to_back();
`ifdef VOTER_TIMEOUT_EN
    test_timeout();
`endif
    for (int p = 0; p < 16; p++) test_block_vote(4'(p));
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d results still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/voter_ballot.md
# voter_ballot

Sequential ballot collector for a four-member voting panel. It opens a voting session on command and accepts exactly one vote per member through a per-member valid strobe. It closes the session when all members have voted, or when the window timer expires if the timeout feature is compiled in. It then holds a stable 4-bit ballot vector for the downstream combinational voter, together with its own tally and verdict.

## Interface
- `WINDOW`, default 16: session length in CLK cycles, counted from the first OPEN cycle; legal range 1–255.
- `CLK` input 1: single clock; all state changes on its rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `START` input 1: single-cycle request to open a session; honoured only in IDLE or HOLD.
- `VOTE_VLD` input 4: bit k marks a vote from member k in this cycle.
- `VOTE_VAL` input 4: bit k is member k's vote, 1 = yes; sampled only when `VOTE_VLD[k]` = 1.
- `I` output 4: ballot vector, bit k = member k's recorded vote; abstain or not-yet-voted = 0; feeds the voter's `I`.
- `CAST` output 4: bit k = 1 once member k has voted in the current session.
- `YES_CNT` output 3: number of yes votes recorded, 0–4.
- `VERDICT` output 2: 2'b01 = pass (YES_CNT ≥ 3); 2'b10 = tie (YES_CNT = 2 with all 4 cast); 2'b00 = fail or no verdict.
- `BUSY` output 1: high in OPEN and CLOSE.
- `DONE` output 1: one-cycle pulse on entry to HOLD.

## Operation
- States:
  - IDLE: after reset.
  - OPEN: accepting votes.
  - CLOSE: one cycle; computes the verdict.
  - HOLD: result frozen.
- Transitions:
  - IDLE→OPEN on `START`.
  - OPEN→CLOSE when `CAST` = 4'b1111 after the current cycle's votes are applied, or on timer expiry when timeout is enabled.
  - CLOSE→HOLD unconditionally.
  - HOLD→OPEN on `START`.
- Entering OPEN clears `I`, `CAST`, `YES_CNT` and `VERDICT`, and loads the timer with `WINDOW`-1.
- In OPEN, for each k with `VOTE_VLD[k]` = 1 and `CAST[k]` = 0: set `CAST[k]`, set `I[k]` = `VOTE_VAL[k]`, and add `VOTE_VAL[k]` to `YES_CNT`.
  - Several members may vote in the same cycle; `YES_CNT` adds the popcount of the newly accepted yes votes.
- A repeat vote from a member with `CAST[k]` = 1 is ignored: no change to `I`, `CAST` or `YES_CNT`.
- Votes presented outside OPEN are ignored.
- `START` while in OPEN or CLOSE is ignored.
- `VERDICT` is written in CLOSE. It stays at 2'b00 in every other state, except that it is held through HOLD.
- Abstainers count as no votes; a tie verdict needs all four votes cast.

## Timing
- Reset values: state = IDLE; `I` = 0, `CAST` = 0, `YES_CNT` = 0, `VERDICT` = 0, `BUSY` = 0, `DONE` = 0; timer = 0.
- `RST` asserted mid-session aborts it immediately; no `DONE` pulse follows.
- `START` at edge n: `BUSY` = 1 from cycle n+1.
- A vote at edge m is visible on `I`, `CAST` and `YES_CNT` from cycle m+1.
- Final vote at edge m:
  - CLOSE in cycle m+1.
  - `VERDICT` valid and `DONE` = 1 in cycle m+2.
  - `BUSY` = 0 from cycle m+2.
- Timer expiry: the last OPEN cycle is cycle `WINDOW` of the session. Votes in that cycle are still accepted, and CLOSE follows.
- The final vote and timer expiry in the same cycle produce one close; the vote is counted.
- `START` in the same cycle as the `DONE` pulse: accepted, and the next session opens the following cycle.
- Every output is registered; no combinational path from any input to any output.

## Configuration
- `VOTER_TIMEOUT_EN` defined:
  - The window timer is present.
  - The session closes at `WINDOW` cycles even if some members have not voted.
  - Members who did not vote read as 0 on `I` and leave their `CAST` bit clear.
- `VOTER_TIMEOUT_EN` undefined:
  - No timer logic is built and `WINDOW` is ignored.
  - The session closes only when all four members have voted; OPEN can persist indefinitely.

## Test plan
- Reset mid-OPEN with `CAST` = 4'b0011: all outputs read 0 within the reset cycle; state = IDLE; no `DONE` pulse.
- `START`, then one cycle with `VOTE_VLD` = 4'b1111 and `VOTE_VAL` = 4'b1011:
  - `I` = 4'b1011, `YES_CNT` = 3.
  - Two cycles later `VERDICT` = 01 and `DONE` = 1.
- Serial votes, member 0 yes, member 1 no, member 2 yes, member 3 no:
  - A second `VOTE_VLD[0]` with `VOTE_VAL[0]` = 0 is ignored.
  - Result: `I` = 4'b0101, `YES_CNT` = 2, `VERDICT` = 10.
- `VOTER_TIMEOUT_EN`, `WINDOW` = 4, only member 2 votes yes:
  - CLOSE after 4 OPEN cycles.
  - Result: `I` = 4'b0100, `CAST` = 4'b0100, `VERDICT` = 00.
- `START` pulsed during OPEN and votes presented in HOLD: no state change and no tally change; `START` in HOLD reopens with `I` = 0.
- All 16 `VOTE_VAL` patterns, each applied with `VOTE_VLD` = 4'b1111: `I` equals the pattern; `YES_CNT` equals its popcount; `VERDICT` = 01 for popcount ≥ 3, 10 for popcount = 2, otherwise 00.
